instr_prefetch_queue: RTL
=========================

Name: instr_prefetch_queue

Overview:
- Instruction fetch stage between the 16x1024 program RAM and the simple_proc_data_proc data path.
- Generates sequential program addresses and read enables toward the RAM.
- Buffers returned 16-bit instruction words in a small FIFO and presents them to the processor with a valid/ready handshake.
- Handles redirects (branches) by flushing, and stops fetching after the halt word 16'h3c00.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
ADDR_W, 8, program address width; fetch address wraps modulo 2^ADDR_W
HALT_WORD, 16'h3c00, instruction encoding that stops fetching

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level; 1 enables fetching from IDLE
ram_read_en  output  1  program RAM read strobe
ram_addr  output  ADDR_W  program RAM address
ram_dout  input  16  RAM read data, valid exactly 1 cycle after ram_read_en
redirect  input  1  1-cycle pulse: flush and refetch from redirect_addr
redirect_addr  input  ADDR_W  new fetch address, sampled when redirect=1
instr_out  output  16  head-of-queue instruction
instr_pc  output  ADDR_W  address the head instruction was fetched from
instr_vld  output  1  head entry valid
instr_rdy  input  1  consumer accepts head when instr_vld & instr_rdy
halted  output  1  halt word enqueued; fetching stopped
fill_level  output  $clog2(DEPTH)+1  entries currently held

Behaviour:
- Reset (async assert, sync release):
  - ram_read_en=0, ram_addr=0, instr_vld=0, instr_out=0, instr_pc=0, halted=0, fill_level=0.
  - Fetch pointer=0, in-flight flag=0, state=IDLE.
- States:
  - IDLE: no reads. Go to FETCH when start=1.
  - FETCH: issue reads.
  - HALTED: no reads; halted=1.
- Read issue (FETCH only), ram_read_en=1 in a cycle iff all of the following hold:
  - start=1
  - redirect=0
  - (fill_level + in_flight - pop_this_cycle) < DEPTH
  - On issue: ram_addr = fetch pointer, fetch pointer increments, wrapping 8'hFF->8'h00.
  - Back-to-back reads allowed every cycle.
- start deasserted in FETCH:
  - Issuing stops; the in-flight word is still enqueued; state stays FETCH.
- Return: the cycle after an issued read, ram_dout is pushed with its fetch address unless discarded.
  - Fill_level is updated in the same clock edge.
  - Latency from read issue to instr_vld = 2 cycles when the queue is empty.
- Pop: on instr_vld & instr_rdy the head is removed at the clock edge.
  - Push and pop in the same cycle are both honored; fill_level is unchanged.
- Full:
  - Issue gating guarantees a push never hits a full queue.
  - A push into a full queue is a design error; the sim assertion must fire.
- Empty: instr_vld=0; instr_out and instr_pc hold their last values.
- Halt:
  - When a pushed word equals HALT_WORD, state becomes HALTED and halted=1 on the next cycle.
  - Any read issued in the same cycle as that push is discarded on return.
  - Queued entries, including the halt word, still drain normally.
- Redirect (highest priority):
  - Queue and in-flight data are cleared; a pop in the same cycle is treated as consumed.
  - Fetch pointer = redirect_addr; halted cleared.
  - State becomes FETCH if start=1, else IDLE.
  - The first new read issues the cycle after redirect.
  - A return arriving the cycle after redirect is discarded.
- Reset mid-operation: immediate return to reset values; in-flight data is lost.

Optional Feature:
IFQ_STALL_CNT_EN:
- Defined:
  - Adds output stall_cnt [15:0], reset 0.
  - Increments (saturating at 16'hFFFF) each cycle instr_vld=0 && state==FETCH && start=1.
  - Cleared by redirect.
- Undefined: port and counter absent; the remaining behaviour is identical.

Test Plan:
- Linear fetch: RAM[0..5]=16'h1001..16'h1006, instr_rdy=1, start=1 -> ram_addr 0,1,2,... on consecutive cycles; instr_out 1001..1006 in order; first instr_vld 2 cycles after first read; instr_pc 0..5.
- Backpressure: instr_rdy=0 for 10 cycles -> exactly DEPTH=4 reads issued; fill_level=4; no read while full; after instr_rdy=1, all words delivered in order with no loss or duplication.
- Halt: RAM[3]=16'h3c00 -> halted=1 after word 3 is enqueued; no ram_read_en afterwards; words 0..3 delivered; word 4 never appears.
- Redirect: redirect=1 with redirect_addr=8'h40 while 3 entries are queued and 1 read is in flight -> fill_level=0 next cycle; stale return discarded; next instr_out=RAM[8'h40] with instr_pc=8'h40.
- Wrap: redirect_addr=8'hFE -> fetched pcs are FE, FF, 00, 01.
- Reset: assert rst_n=0 mid-stream with 2 entries queued -> all outputs 0 asynchronously; after release and start=1, fetching restarts at address 0.

Source files
------------

// File: rtl/instr_prefetch_queue_if.sv
// ---------------------------------------------------------------------------
// instr_prefetch_queue_if
//
// Bundles the two buses of the instruction prefetch queue:
//   - program RAM side : ram_read_en, ram_addr (to RAM), ram_dout (from RAM)
//   - consumer side    : instr_out, instr_pc, instr_vld (to processor),
//                        instr_rdy (from processor)
//
// Modports:
//   master : the prefetch queue itself (drives RAM requests and the head entry)
//   slave  : the environment (RAM model + consuming data path)
// ---------------------------------------------------------------------------
interface instr_prefetch_queue_if #(
    parameter int ADDR_W = 8
);
    logic              ram_read_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_dout;

    logic [15:0]       instr_out;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_vld;
    logic              instr_rdy;

    modport master (
        output ram_read_en,
        output ram_addr,
        input  ram_dout,
        output instr_out,
        output instr_pc,
        output instr_vld,
        input  instr_rdy
    );

    modport slave (
        input  ram_read_en,
        input  ram_addr,
        output ram_dout,
        input  instr_out,
        input  instr_pc,
        input  instr_vld,
        output instr_rdy
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// ---------------------------------------------------------------------------
// instr_prefetch_queue
//
// Instruction fetch stage between the 16x1024 program RAM and the
// simple_proc_data_proc data path. Issues sequential program reads, buffers
// the returned words with their fetch address in a DEPTH-entry FIFO and
// presents the head entry with a valid/ready handshake. A redirect flushes
// everything and restarts fetching at a new address; fetching stops once the
// halt word has been enqueued.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   level, enables fetching
//   redirect       in   1-cycle pulse: flush and refetch from redirect_addr
//   redirect_addr  in   new fetch address
//   halted         out  halt word enqueued, fetching stopped
//   fill_level     out  entries currently held in the queue
//   bus (master)   ram_read_en/ram_addr/ram_dout toward program RAM,
//                  instr_out/instr_pc/instr_vld/instr_rdy toward consumer
//   stall_cnt      out  (only with IFQ_STALL_CNT_EN) saturating count of
//                  cycles spent fetching with nothing to present
//
// Optional feature macro: IFQ_STALL_CNT_EN
// ---------------------------------------------------------------------------
module instr_prefetch_queue #(
    parameter int          DEPTH     = 4,
    parameter int          ADDR_W    = 8,
    parameter logic [15:0] HALT_WORD = 16'h3c00
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_addr,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   fill_level,
    instr_prefetch_queue_if.master   bus
`ifdef IFQ_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] fetch_ptr;

    logic              issue_p0;
    logic              vld_p1;      // a read issued last cycle returns now
    logic [ADDR_W-1:0] addr_p1;     // address of that read

    logic [15:0]       mem_word [DEPTH];
    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [15:0]       head_word;
    logic [ADDR_W-1:0] head_pc;

    logic              push;
    logic              pop;
    logic              halt_hit;
    logic [CNT_W:0]    occupancy;
    logic [CNT_W-1:0]  count_after_pop;
    logic [PTR_W-1:0]  rd_ptr_pop;

    assign pop  = (count != '0) && bus.instr_rdy;
    // A return in the redirect cycle belongs to the old stream.
    assign push = vld_p1 && !redirect;
    assign halt_hit = push && (bus.ram_dout == HALT_WORD);

    // Entries that will exist once the current return is pushed and the
    // current pop is taken; a new read is only safe if that leaves room.
    always_comb begin
        occupancy       = {1'b0, count} + (CNT_W+1)'(vld_p1) - (CNT_W+1)'(pop);
        count_after_pop = count - CNT_W'(pop);
        rd_ptr_pop      = rd_ptr + PTR_W'(pop);
        issue_p0        = (state == ST_FETCH) && start && !redirect &&
                          (occupancy < (CNT_W+1)'(DEPTH));
    end

    // ---- stage 0: read issue toward program RAM ----
    assign bus.ram_read_en = issue_p0;
    assign bus.ram_addr    = fetch_ptr;

    // ---- stage 1: RAM return, FIFO push/pop, head register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            fetch_ptr <= '0;
            vld_p1    <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            head_word <= '0;
            head_pc   <= '0;
        end else if (redirect) begin
            // Head register keeps its last value so an empty queue still
            // shows the most recent instruction.
            state     <= start ? ST_FETCH : ST_IDLE;
            fetch_ptr <= redirect_addr;
            vld_p1    <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            // A read issued alongside the halt-word push is dropped on return.
            vld_p1 <= issue_p0 && !halt_hit;
            if (issue_p0)
                fetch_ptr <= fetch_ptr + 1'b1;

            case (state)
                ST_IDLE:  if (start)    state <= ST_FETCH;
                ST_FETCH: if (halt_hit) state <= ST_HALTED;
                default:                state <= state;
            endcase

            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr_pop;
            count <= count + CNT_W'(push) - CNT_W'(pop);

            // Next head is either an entry already stored or, when the queue
            // drains to empty this edge, the word being pushed right now.
            if (count_after_pop != '0) begin
                head_word <= mem_word[rd_ptr_pop];
                head_pc   <= mem_pc[rd_ptr_pop];
            end else if (push) begin
                head_word <= bus.ram_dout;
                head_pc   <= addr_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue_p0)
            addr_p1 <= fetch_ptr;
        if (push) begin
            mem_word[wr_ptr] <= bus.ram_dout;
            mem_pc[wr_ptr]   <= addr_p1;
        end
    end

    assign bus.instr_vld = (count != '0);
    assign bus.instr_out = head_word;
    assign bus.instr_pc  = head_pc;
    assign halted        = (state == ST_HALTED);
    assign fill_level    = count;

`ifdef IFQ_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (redirect)
            stall_cnt <= '0;
        else if ((count == '0) && (state == ST_FETCH) && start &&
                 (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

    // Issue gating must never let a return land in a full queue.
    assert property (@(posedge clk) disable iff (!rst_n)
                     push |-> (count < CNT_W'(DEPTH)));

endmodule
